// File: rtl/drumbit_pkg.sv
// Shared types for the drumbit sequencer and player.
// Used by step_player (optional swing build: STEP_PLAYER_SWING_EN).
package drumbit_pkg;

  localparam int unsigned NUM_STEPS = 8;
  localparam int unsigned NUM_SMPL  = 4;

  typedef logic [2:0] step_t;
  typedef logic [NUM_SMPL-1:0] smpl_t;

  typedef enum logic [1:0] {
    P_STOP,
    P_RUN,
    P_PAUSE
  } player_state_t;

endpackage

// File: rtl/step_player_if.sv
// Transport, pattern and trigger signals between the controller and step_player.
// The swing_on signal exists only when STEP_PLAYER_SWING_EN is defined.
interface step_player_if #(
  parameter int unsigned CNT_W = 16
);
  import drumbit_pkg::*;

  logic             play_pause;
  logic             stop;
  logic [CNT_W-1:0] period;
`ifdef STEP_PLAYER_SWING_EN
  logic             swing_on;
`endif
  smpl_t            seq_smpl_1;
  smpl_t            seq_smpl_2;
  smpl_t            seq_smpl_3;
  smpl_t            seq_smpl_4;
  smpl_t            seq_smpl_5;
  smpl_t            seq_smpl_6;
  smpl_t            seq_smpl_7;
  smpl_t            seq_smpl_8;
  smpl_t            trig;
  step_t            step_idx;
  logic             step_tick;
  logic             bar_start;
  logic             playing;

  modport master (
`ifdef STEP_PLAYER_SWING_EN
    output swing_on,
`endif
    output play_pause, stop, period,
    output seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
    output seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
    input  trig, step_idx, step_tick, bar_start, playing
  );

  modport slave (
`ifdef STEP_PLAYER_SWING_EN
    input  swing_on,
`endif
    input  play_pause, stop, period,
    input  seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
    input  seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
    output trig, step_idx, step_tick, bar_start, playing
  );

endinterface

// File: rtl/tempo_timer.sv
// Per-step cycle counter producing a boundary strobe at the end of each step.
// Swing step lengths are compiled in with STEP_PLAYER_SWING_EN.
module tempo_timer
  import drumbit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] period_i,
`ifdef STEP_PLAYER_SWING_EN
  input  step_t            step_idx_i,
  input  logic             swing_on_i,
`endif
  output logic             boundary_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   per_ext;
  logic [CNT_W:0]   quarter;
  logic [CNT_W:0]   limit;

  assign per_ext = {1'b0, period_i};
  assign quarter = per_ext >> 2;

  // One extra bit keeps the long swing step from wrapping.
  always_comb begin
    limit = (period_i == '0) ? '0 : per_ext - 1'b1;
`ifdef STEP_PLAYER_SWING_EN
    if (swing_on_i && (|period_i[CNT_W-1:2])) begin
      limit = step_idx_i[0] ? (per_ext - quarter - 1'b1) : (per_ext + quarter - 1'b1);
    end
`endif
  end

  assign boundary_o = run_i && ({1'b0, cnt_q} >= limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = boundary_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/step_player.sv
// Step sequencer playback: transport FSM, step pointer and registered trigger pulses.
// Define STEP_PLAYER_SWING_EN to enable swing timing via bus.swing_on.
module step_player
  import drumbit_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned NUM_STEPS = 8
) (
  input logic        clk,
  input logic        rst,
  step_player_if.slave bus
);

  player_state_t state_q;
  step_t         step_q;
  smpl_t         trig_q;
  logic          tick_q;
  logic          bar_q;
  logic          playing_q;

  smpl_t [7:0]   pats;
  step_t         next_step;
  logic          advance;
  logic          clear;
  logic          boundary;

  assign pats = {bus.seq_smpl_8, bus.seq_smpl_7, bus.seq_smpl_6, bus.seq_smpl_5,
                 bus.seq_smpl_4, bus.seq_smpl_3, bus.seq_smpl_2, bus.seq_smpl_1};

  assign next_step = (step_q == step_t'(NUM_STEPS - 1)) ? '0 : step_q + 3'd1;

  // Stop and pause both take priority over a step boundary in the same cycle.
  assign advance = (state_q == P_RUN) && !bus.stop && !bus.play_pause;
  assign clear   = bus.stop || (state_q == P_STOP);

  tempo_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run_i      (advance),
    .clear_i    (clear),
    .period_i   (bus.period),
`ifdef STEP_PLAYER_SWING_EN
    .step_idx_i (step_q),
    .swing_on_i (bus.swing_on),
`endif
    .boundary_o (boundary)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= P_STOP;
      step_q    <= '0;
      trig_q    <= '0;
      tick_q    <= 1'b0;
      bar_q     <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      trig_q <= '0;
      tick_q <= 1'b0;
      bar_q  <= 1'b0;
      unique case (state_q)
        P_STOP: begin
          if (bus.play_pause && !bus.stop) begin
            state_q   <= P_RUN;
            step_q    <= '0;
            trig_q    <= pats[0];
            tick_q    <= 1'b1;
            bar_q     <= 1'b1;
            playing_q <= 1'b1;
          end
        end
        P_RUN: begin
          if (bus.stop) begin
            state_q   <= P_STOP;
            step_q    <= '0;
            playing_q <= 1'b0;
          end else if (bus.play_pause) begin
            state_q   <= P_PAUSE;
            playing_q <= 1'b0;
          end else if (boundary) begin
            step_q <= next_step;
            trig_q <= pats[next_step];
            tick_q <= 1'b1;
            bar_q  <= (next_step == '0);
          end
        end
        P_PAUSE: begin
          if (bus.stop) begin
            state_q <= P_STOP;
            step_q  <= '0;
          end else if (bus.play_pause) begin
            state_q   <= P_RUN;
            playing_q <= 1'b1;
          end
        end
        default: state_q <= P_STOP;
      endcase
    end
  end

  assign bus.trig      = trig_q;
  assign bus.step_idx  = step_q;
  assign bus.step_tick = tick_q;
  assign bus.bar_start = bar_q;
  assign bus.playing   = playing_q;

endmodule

// File: tb/tb_step_player.sv
// Self-checking bench for step_player: directed transport scenarios plus a random run,
// all compared against a step-duration reference model.
module tb_step_player;
  import drumbit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic swing;

  step_player_if #(.CNT_W(16)) bus ();

  step_player #(
    .CNT_W    (16),
    .NUM_STEPS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef STEP_PLAYER_SWING_EN
  assign bus.swing_on = swing;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=stopped 1=running 2=paused; elapsed = cycles spent in the step.
  int          m_mode, m_step, m_elapsed;
  logic [3:0]  e_trig;
  logic        e_tick, e_bar, e_play;
  logic [3:0]  pats [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step_len(input int step, input int per, input bit sw);
    if (sw && per >= 4) return (step % 2 == 0) ? per + per / 4 : per - per / 4;
    return (per == 0) ? 1 : per;
  endfunction

  task automatic drive_pats();
    bus.seq_smpl_1 = pats[0];
    bus.seq_smpl_2 = pats[1];
    bus.seq_smpl_3 = pats[2];
    bus.seq_smpl_4 = pats[3];
    bus.seq_smpl_5 = pats[4];
    bus.seq_smpl_6 = pats[5];
    bus.seq_smpl_7 = pats[6];
    bus.seq_smpl_8 = pats[7];
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bus.trig, bus.step_idx, bus.step_tick, bus.bar_start, bus.playing});
  endfunction

  // One clock: update the model from the inputs present at the edge, then compare.
  task automatic cycle();
    bit pp, st, r, sw;
    int per;
    pp  = bus.play_pause;
    st  = bus.stop;
    r   = rst;
    per = int'(bus.period);
`ifdef STEP_PLAYER_SWING_EN
    sw  = swing;
`else
    sw  = 1'b0;
`endif
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_step = 0; m_elapsed = 0;
      e_trig = 4'h0; e_tick = 0; e_bar = 0; e_play = 0;
    end else begin
      e_trig = 4'h0; e_tick = 0; e_bar = 0;
      case (m_mode)
        0: if (pp && !st) begin
          m_mode = 1; m_step = 0; m_elapsed = 0;
          e_trig = pats[0]; e_tick = 1; e_bar = 1; e_play = 1;
        end
        1: if (st) begin
          m_mode = 0; m_step = 0; m_elapsed = 0; e_play = 0;
        end else if (pp) begin
          m_mode = 2; e_play = 0;
        end else if (m_elapsed + 1 >= step_len(m_step, per, sw)) begin
          m_step = (m_step + 1) % 8; m_elapsed = 0;
          e_trig = pats[m_step]; e_tick = 1; e_bar = (m_step == 0);
        end else begin
          m_elapsed++;
        end
        default: if (st) begin
          m_mode = 0; m_step = 0; m_elapsed = 0;
        end else if (pp) begin
          m_mode = 1; e_play = 1;
        end
      endcase
    end
    #1;
    check("outputs", dut_vec(), 32'({e_trig, 3'(m_step), e_tick, e_bar, e_play}));
    bus.play_pause = 1'b0;
    bus.stop       = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int cnt_a, cnt_b, n;
    bit found;
    logic [3:0] newpat;

    m_mode = 0; m_step = 0; m_elapsed = 0;
    e_trig = 0; e_tick = 0; e_bar = 0; e_play = 0;
    swing = 1'b0;
    bus.play_pause = 1'b0;
    bus.stop = 1'b0;
    bus.period = 16'd4;
    for (int i = 0; i < 8; i++) pats[i] = 4'($urandom);
    pats[0] = 4'b0001;
    drive_pats();

    // Reset and start at cycle 10.
    rst = 1'b1;
    cycle();
    check("reset_idle", dut_vec(), 32'h0);
    run(9);
    bus.play_pause = 1'b1;
    cycle();
    check("start_trig", 32'(bus.trig), 32'h1);
    check("start_bar", 32'(bus.bar_start), 32'h1);
    check("start_step", 32'(bus.step_idx), 32'h0);
    run(3);
    cycle();
    check("step1_idx", 32'(bus.step_idx), 32'h1);
    check("step1_trig", 32'(bus.trig), 32'(pats[1]));

    // Wrap with period 2.
    bus.stop = 1'b1;
    cycle();
    bus.period = 16'd2;
    for (int i = 0; i < 8; i++) pats[i] = 4'hF;
    drive_pats();
    bus.play_pause = 1'b1;
    cycle();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (bus.trig != 4'h0) cnt_a++;
      if (bus.bar_start) cnt_b++;
    end
    check("wrap_trigs16", 32'(cnt_a), 32'd8);
    check("wrap_bars16", 32'(cnt_b), 32'd1);
    check("wrap_idx", 32'(bus.step_idx), 32'h0);
    run(4);

    // Pause at count 3 of step 2, hold, resume.
    bus.stop = 1'b1;
    cycle();
    bus.period = 16'd8;
    for (int i = 0; i < 8; i++) pats[i] = 4'($urandom_range(1, 15));
    drive_pats();
    bus.play_pause = 1'b1;
    cycle();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_step == 2 && m_elapsed == 3) found = 1;
      else cycle();
    end
    check("pause_point_found", 32'(found), 32'h1);
    bus.play_pause = 1'b1;
    cycle();
    check("paused_playing", 32'(bus.playing), 32'h0);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.step_tick || bus.trig != 4'h0 || bus.bar_start) cnt_a++;
    end
    check("pause_no_pulses", 32'(cnt_a), 32'h0);
    bus.play_pause = 1'b1;
    cycle();
    check("resume_no_retrig", 32'(bus.step_tick), 32'h0);
    n = 0; found = 0;
    for (int i = 1; i <= 12 && !found; i++) begin
      cycle();
      if (bus.step_tick) begin found = 1; n = i; end
    end
    // Step 2 had counted 3 of 8 cycles, so 5 more running cycles end it.
    check("resume_latency", 32'(n), 32'd5);
    check("resume_step3", 32'(bus.step_idx), 32'd3);

    // Stop beats play_pause.
    run(5);
    bus.stop = 1'b1;
    bus.play_pause = 1'b1;
    cycle();
    check("stop_priority", dut_vec(), 32'h0);

    // Synchronous reset while running.
    bus.play_pause = 1'b1;
    cycle();
    run(5);
    rst = 1'b1;
    cycle();
    check("reset_midrun", dut_vec(), 32'h0);

    // Period 0 steps every cycle.
    bus.period = 16'd0;
    bus.play_pause = 1'b1;
    cycle();
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.step_tick) cnt_a++;
    end
    check("period0_ticks", 32'(cnt_a), 32'd8);

    // Edit step 4's pattern while it sounds; new value on its next start.
    bus.stop = 1'b1;
    cycle();
    bus.period = 16'd4;
    bus.play_pause = 1'b1;
    cycle();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (bus.step_idx == 3'd3 && bus.step_tick) found = 1;
    end
    check("edit_first_found", 32'(found), 32'h1);
    newpat = ~pats[3];
    pats[3] = newpat;
    drive_pats();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (bus.step_idx == 3'd3 && bus.step_tick) found = 1;
    end
    check("edit_second_found", 32'(found), 32'h1);
    check("edit_trig", 32'(bus.trig), 32'(newpat));

`ifdef STEP_PLAYER_SWING_EN
    // Swing: 10/6 at period 8, plain 3 at period 3.
    bus.stop = 1'b1;
    cycle();
    swing = 1'b1;
    bus.period = 16'd8;
    bus.play_pause = 1'b1;
    cycle();
    for (int s = 0; s < 4; s++) begin
      n = 0; found = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
        cycle();
        if (bus.step_tick) begin found = 1; n = i; end
      end
      check("swing_len", 32'(n), (s % 2 == 0) ? 32'd10 : 32'd6);
    end
    bus.stop = 1'b1;
    cycle();
    bus.period = 16'd3;
    bus.play_pause = 1'b1;
    cycle();
    for (int s = 0; s < 2; s++) begin
      n = 0; found = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
        cycle();
        if (bus.step_tick) begin found = 1; n = i; end
      end
      check("swing_short_len", 32'(n), 32'd3);
    end
`endif

    // Random transport, tempo and pattern traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) bus.play_pause = 1'b1;
      if ($urandom_range(0, 39) == 0) bus.stop = 1'b1;
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 31) == 0) bus.period = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0) swing = ~swing;
      if ($urandom_range(0, 7) == 0) begin
        pats[$urandom_range(0, 7)] = 4'($urandom);
        drive_pats();
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
